// File: rtl/mig_sched_pkg.sv
// Shared types and command encodings for the MIG read/write scheduler.
package mig_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_TURN     = 2'd1,
        ST_WR_BURST = 2'd2,
        ST_RD_BURST = 2'd3
    } state_e;

    typedef enum logic {
        DIR_WRITE = 1'b0,
        DIR_READ  = 1'b1
    } dir_e;

    localparam logic [2:0] MIG_CMD_WRITE = 3'b000;
    localparam logic [2:0] MIG_CMD_READ  = 3'b001;

    function automatic state_e burst_state(input dir_e d);
        return (d == DIR_WRITE) ? ST_WR_BURST : ST_RD_BURST;
    endfunction

endpackage

// File: rtl/mig_burst_counter.sv
// Address/beat counter shared by both burst directions; flags the final beat.
module mig_burst_counter #(
    parameter int ADDR_W    = 28,
    parameter int LEN_W     = 5,
    parameter int ADDR_STEP = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [LEN_W-1:0]  load_len,
    input  logic              fire,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        addr_d = addr_q;
        cnt_d  = cnt_q;
        if (load) begin
            addr_d = load_addr;
            cnt_d  = load_len;
        end else if (fire) begin
            // Address wraps silently at the top of the MIG address space.
            addr_d = addr_q + ADDR_W'(ADDR_STEP);
            cnt_d  = cnt_q - LEN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q <= '0;
            cnt_q  <= '0;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign addr = addr_q;
    assign last = (cnt_q == LEN_W'(1));

endmodule

// File: rtl/mig_rw_scheduler.sv
// Arbitrates write-drain and read-fill bursts onto the MIG native command port.
// Build option MIG_SCHED_WR_PRIORITY_EN: writes win ties instead of round-robin.
module mig_rw_scheduler
    import mig_sched_pkg::*;
#(
    parameter int Max_Burst_Len      = 16,
    parameter int RW_Delay_Value     = 4,
    parameter int MIG_Data_Port_Size = 128,
    parameter int MIG_Addr_Port_Size = 28,
    parameter int Addr_Step          = 8,
    localparam int LEN_W             = $clog2(Max_Burst_Len + 1)
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          init_calib,
    input  logic                          wr_req,
    input  logic [MIG_Addr_Port_Size-1:0] wr_addr,
    input  logic [LEN_W-1:0]              wr_len,
    input  logic [MIG_Data_Port_Size-1:0] wr_tdata,
    input  logic                          wr_tvalid,
    output logic                          wr_tready,
    output logic                          wr_done,
    input  logic                          rd_req,
    input  logic [MIG_Addr_Port_Size-1:0] rd_addr,
    input  logic [LEN_W-1:0]              rd_len,
    output logic                          rd_done,
    output logic [MIG_Addr_Port_Size-1:0] app_addr,
    output logic [2:0]                    app_cmd,
    output logic                          app_en,
    input  logic                          app_rdy,
    output logic [MIG_Data_Port_Size-1:0] app_wdf_data,
    output logic                          app_wdf_wren,
    output logic                          app_wdf_end,
    input  logic                          app_wdf_rdy,
    output logic                          busy
);

    localparam int TURN_W = (RW_Delay_Value > 1) ? $clog2(RW_Delay_Value) : 1;
    localparam logic [TURN_W-1:0] TURN_INIT =
        TURN_W'((RW_Delay_Value > 0) ? (RW_Delay_Value - 1) : 0);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(Max_Burst_Len);

    state_e            state_q, state_d;
    dir_e              last_dir_q, last_dir_d;
    dir_e              dir_q, dir_d;
    logic [TURN_W-1:0] turn_cnt_q, turn_cnt_d;
    logic              wr_done_q, wr_done_d;
    logic              rd_done_q, rd_done_d;

    logic                          gnt;
    dir_e                          gnt_dir;
    logic                          ld, last, fire;
    logic [MIG_Addr_Port_Size-1:0] ld_addr, cur_addr;
    logic [LEN_W-1:0]              req_len, ld_len;

    mig_burst_counter #(
        .ADDR_W    (MIG_Addr_Port_Size),
        .LEN_W     (LEN_W),
        .ADDR_STEP (Addr_Step)
    ) u_cnt (
        .clk       (aclk),
        .rst_n     (aresetn),
        .load      (ld),
        .load_addr (ld_addr),
        .load_len  (ld_len),
        .fire      (fire),
        .addr      (cur_addr),
        .last      (last)
    );

    // Write commands are only offered when their data can go out in the same cycle.
    always_comb begin
        app_en = 1'b0;
        if (state_q == ST_WR_BURST) app_en = wr_tvalid & app_wdf_rdy;
        else if (state_q == ST_RD_BURST) app_en = 1'b1;
    end

    assign fire         = app_en & app_rdy;
    assign wr_tready    = fire & (state_q == ST_WR_BURST);
    assign app_wdf_wren = wr_tready;
    assign app_wdf_end  = wr_tready;
    assign app_wdf_data = wr_tdata;
    assign app_cmd      = (state_q == ST_RD_BURST) ? MIG_CMD_READ : MIG_CMD_WRITE;
    assign app_addr     = cur_addr;
    assign busy         = (state_q != ST_IDLE);
    assign wr_done      = wr_done_q;
    assign rd_done      = rd_done_q;

    // A done pulse blocks one grant so the finished requester can drop its req.
    always_comb begin
        gnt = init_calib & ~wr_done_q & ~rd_done_q & (wr_req | rd_req);
        if (wr_req && rd_req) begin
`ifdef MIG_SCHED_WR_PRIORITY_EN
            gnt_dir = DIR_WRITE;
`else
            gnt_dir = (last_dir_q == DIR_READ) ? DIR_WRITE : DIR_READ;
`endif
        end else begin
            gnt_dir = wr_req ? DIR_WRITE : DIR_READ;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_dir_d = last_dir_q;
        dir_d      = dir_q;
        turn_cnt_d = turn_cnt_q;
        wr_done_d  = 1'b0;
        rd_done_d  = 1'b0;
        ld         = 1'b0;
        req_len    = (gnt_dir == DIR_WRITE) ? wr_len : rd_len;
        ld_addr    = (gnt_dir == DIR_WRITE) ? wr_addr : rd_addr;
        ld_len     = (req_len > MAX_LEN) ? MAX_LEN : req_len;

        case (state_q)
            ST_IDLE: begin
                if (gnt) begin
                    ld    = 1'b1;
                    dir_d = gnt_dir;
                    if (req_len == '0) begin
                        wr_done_d = (gnt_dir == DIR_WRITE);
                        rd_done_d = (gnt_dir == DIR_READ);
                    end else if ((RW_Delay_Value > 0) && (gnt_dir != last_dir_q)) begin
                        state_d    = ST_TURN;
                        turn_cnt_d = TURN_INIT;
                    end else begin
                        state_d = burst_state(gnt_dir);
                    end
                end
            end
            ST_TURN: begin
                if (turn_cnt_q == '0) state_d = burst_state(dir_q);
                else                  turn_cnt_d = turn_cnt_q - TURN_W'(1);
            end
            ST_WR_BURST, ST_RD_BURST: begin
                if (fire && last) begin
                    state_d    = ST_IDLE;
                    last_dir_d = dir_q;
                    wr_done_d  = (dir_q == DIR_WRITE);
                    rd_done_d  = (dir_q == DIR_READ);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q    <= ST_IDLE;
            last_dir_q <= DIR_READ;
            dir_q      <= DIR_WRITE;
            turn_cnt_q <= '0;
            wr_done_q  <= 1'b0;
            rd_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_dir_q <= last_dir_d;
            dir_q      <= dir_d;
            turn_cnt_q <= turn_cnt_d;
            wr_done_q  <= wr_done_d;
            rd_done_q  <= rd_done_d;
        end
    end

endmodule

// File: tb/tb_mig_rw_scheduler.sv
// Scoreboard bench for mig_rw_scheduler: directed bursts, monitor checks each accepted command.
`timescale 1ns/1ps
module tb_mig_rw_scheduler;

    localparam int AW = 28;
    localparam int DW = 128;
    localparam int LW = 5;
    localparam int RW = 4;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          init_calib = 1'b0;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [LW-1:0] wr_len = '0;
    logic [DW-1:0] wr_tdata = '0;
    logic          wr_tvalid = 1'b1;
    logic          wr_tready, wr_done;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [LW-1:0] rd_len = '0;
    logic          rd_done;
    logic [AW-1:0] app_addr;
    logic [2:0]    app_cmd;
    logic          app_en;
    logic          app_rdy = 1'b1;
    logic [DW-1:0] app_wdf_data;
    logic          app_wdf_wren, app_wdf_end;
    logic          app_wdf_rdy = 1'b1;
    logic          busy;

    mig_rw_scheduler dut (
        .aclk(aclk), .aresetn(aresetn), .init_calib(init_calib),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len),
        .wr_tdata(wr_tdata), .wr_tvalid(wr_tvalid), .wr_tready(wr_tready), .wr_done(wr_done),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_done(rd_done),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
        .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_wdf_rdy(app_wdf_rdy), .busy(busy)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [2:0]    cmd;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } beat_t;

    beat_t exp_q[$];
    bit    done_q[$];
    int    fire_log[$];
    int    n_chk = 0, n_fail = 0, cyc = 0, fire_cnt = 0;
    int    wr_pushed = 0, wr_fired = 0;
    bit    wr_done_p = 1'b0, rd_done_p = 1'b0;

    always @(posedge aclk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] mkdata(input int i);
        return {32'hC0DE0000 + 32'(i), 32'h12345678, 32'(i) ^ 32'hFFFF0000, 32'hA5A5A5A5};
    endfunction

    function automatic int fire_at(input int idx);
        return (idx < fire_log.size()) ? fire_log[idx] : -1000;
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_burst(input bit rd, input logic [AW-1:0] a, input int n);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.cmd  = rd ? 3'b001 : 3'b000;
            b.addr = a + AW'(k * 8);
            b.data = rd ? '0 : mkdata(wr_pushed);
            if (!rd) wr_pushed++;
            exp_q.push_back(b);
        end
        done_q.push_back(rd);
    endtask

    task automatic set_req(input bit rd, input logic [AW-1:0] a, input logic [LW-1:0] len);
        if (rd) begin rd_addr = a; rd_len = len; rd_req = 1'b1; end
        else    begin wr_addr = a; wr_len = len; wr_req = 1'b1; end
    endtask

    task automatic wait_done(input bit rd, output int done_cyc);
        bit seen = 1'b0;
        done_cyc = -1;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(posedge aclk); #1;
            if (rd ? rd_done : wr_done) begin seen = 1'b1; done_cyc = cyc; end
        end
        if (rd) rd_req = 1'b0; else wr_req = 1'b0;
        chk(rd ? "rd_done_seen" : "wr_done_seen", DW'(seen), DW'(1));
    endtask

    task automatic wait_busy(output int b);
        b = -1;
        for (int i = 0; i < 50 && b < 0; i++) begin
            @(posedge aclk); #1;
            if (busy) b = cyc;
        end
        chk("busy_seen", DW'(b >= 0), DW'(1));
    endtask

    // Monitor: every accepted command is checked against the scoreboard head.
    always @(negedge aclk) begin
        beat_t e;
        if (app_en && app_rdy) begin
            fire_cnt++;
            fire_log.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_cmd: got cmd %0h addr %0h expected no command", app_cmd, app_addr);
            end else begin
                e = exp_q.pop_front();
                chk("app_cmd", DW'(app_cmd), DW'(e.cmd));
                chk("app_addr", DW'(app_addr), DW'(e.addr));
                chk("app_wdf_wren", DW'(app_wdf_wren), DW'(e.cmd == 3'b000));
                chk("app_wdf_end", DW'(app_wdf_end), DW'(e.cmd == 3'b000));
                chk("wr_tready", DW'(wr_tready), DW'(e.cmd == 3'b000));
                if (e.cmd == 3'b000) begin
                    chk("app_wdf_data", app_wdf_data, e.data);
                    wr_fired++;
                end
            end
        end else begin
            chk("wdata_without_cmd", DW'({app_wdf_wren, wr_tready}), DW'(0));
        end
        if (wr_done || rd_done) begin
            chk("done_pulse_width", DW'({wr_done & wr_done_p, rd_done & rd_done_p}), DW'(0));
            if (done_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_done: got wr %0b rd %0b expected none", wr_done, rd_done);
            end else begin
                chk("done_dir", DW'({wr_done, rd_done}), done_q.pop_front() ? DW'(2'b01) : DW'(2'b10));
            end
        end
        wr_done_p = wr_done;
        rd_done_p = rd_done;
        wr_tdata  = mkdata(wr_fired);
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish within bound");
        $fatal(1, "timeout");
    end

    initial begin
        int b, d, wd, f0;
        bit ok;

        repeat (3) @(posedge aclk);
        #1;
        chk("rst_app_en", DW'(app_en), DW'(0));
        chk("rst_wren", DW'(app_wdf_wren), DW'(0));
        chk("rst_tready", DW'(wr_tready), DW'(0));
        chk("rst_dones", DW'({wr_done, rd_done}), DW'(0));
        chk("rst_busy", DW'(busy), DW'(0));
        chk("rst_cmd_addr", DW'({app_cmd, app_addr}), DW'(0));
        aresetn = 1'b1;

        // Calibration gate, then first write pays a turnaround (last_dir is READ after reset).
        f0 = fire_cnt;
        push_burst(0, 28'h100, 4);
        set_req(0, 28'h100, 5'd4);
        repeat (4) begin
            @(posedge aclk); #1;
            chk("calib_gate_busy", DW'(busy), DW'(0));
            chk("calib_gate_en", DW'(app_en), DW'(0));
        end
        init_calib = 1'b1;
        @(posedge aclk); #1;
        chk("calib_grant_busy", DW'(busy), DW'(1));
        b = cyc;
        wait_done(0, d);
        chki("wr4_beats", fire_cnt - f0, 4);
        chki("wr4_turn_latency", fire_at(f0) - b, RW);
        chki("wr4_back_to_back", fire_at(f0 + 3) - fire_at(f0), 3);
        chki("wr4_done_after_last", d - fire_at(f0 + 3), 1);

        // Same direction again: no gap, first command in the first busy cycle.
        f0 = fire_cnt;
        push_burst(0, 28'h200, 2);
        set_req(0, 28'h200, 5'd2);
        wait_busy(b);
        wait_done(0, d);
        chki("nt_latency", fire_at(f0) - b, 0);

        // Read with command backpressure on its first two burst cycles.
        f0 = fire_cnt;
        app_rdy = 1'b0;
        push_burst(1, 28'h000, 3);
        set_req(1, 28'h000, 5'd3);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(posedge aclk); #1;
            ok = app_en;
        end
        chk("bp_en_seen", DW'(ok), DW'(1));
        chk("bp_stall1", DW'({app_cmd, app_addr}), DW'({3'b001, 28'h000}));
        @(posedge aclk); #1;
        chk("bp_stall2", DW'({app_en, app_addr}), DW'({1'b1, 28'h000}));
        app_rdy = 1'b1;
        wait_done(1, d);
        chki("bp_beats", fire_cnt - f0, 3);

        // Both requesting after a read: write wins, then read follows after the turnaround.
        f0 = fire_cnt;
        push_burst(0, 28'h300, 2);
        push_burst(1, 28'h400, 2);
        fork
            begin set_req(0, 28'h300, 5'd2); wait_done(0, wd); end
            begin set_req(1, 28'h400, 5'd2); wait_done(1, d); end
        join
        chki("rr_beats", fire_cnt - f0, 4);
        chki("turn_gap", fire_at(f0 + 2) - wd, RW + 2);

        // After a write, a tie goes to read (round-robin) or write (fixed priority).
        push_burst(0, 28'h500, 1);
        set_req(0, 28'h500, 5'd1);
        wait_done(0, d);
`ifdef MIG_SCHED_WR_PRIORITY_EN
        push_burst(0, 28'h600, 1);
        push_burst(1, 28'h700, 1);
`else
        push_burst(1, 28'h700, 1);
        push_burst(0, 28'h600, 1);
`endif
        fork
            begin set_req(0, 28'h600, 5'd1); wait_done(0, wd); end
            begin set_req(1, 28'h700, 5'd1); wait_done(1, d); end
        join

        // Zero-length request: done pulse only.
        f0 = fire_cnt;
        done_q.push_back(1'b0);
        set_req(0, 28'h800, 5'd0);
        wait_done(0, d);
        chki("len0_no_cmd", fire_cnt - f0, 0);

        // Oversized request is clamped to 16 beats.
        f0 = fire_cnt;
        push_burst(1, 28'h1000, 16);
        set_req(1, 28'h1000, 5'd20);
        wait_done(1, d);
        chki("clamp_beats", fire_cnt - f0, 16);

        // Address wrap, with write data briefly unavailable.
        f0 = fire_cnt;
        wr_tvalid = 1'b0;
        push_burst(0, 28'hFFFFFF8, 2);
        set_req(0, 28'hFFFFFF8, 5'd2);
        wait_busy(b);
        repeat (6) @(posedge aclk);
        #1;
        chk("no_tvalid_no_en", DW'({busy, app_en, wr_tready}), DW'(3'b100));
        wr_tvalid = 1'b1;
        wait_done(0, d);
        chki("wrap_beats", fire_cnt - f0, 2);

        // Reset during beat 2 of 8 abandons the burst silently.
        f0 = fire_cnt;
        push_burst(0, 28'h2000, 8);
        set_req(0, 28'h2000, 5'd8);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(posedge aclk); #1;
            ok = (fire_cnt - f0 >= 1);
        end
        chk("rst_burst_started", DW'(ok), DW'(1));
        aresetn = 1'b0;
        wr_req  = 1'b0;
        @(posedge aclk); #1;
        chk("midrst_outs", DW'({app_en, app_wdf_wren, wr_tready, wr_done, rd_done, busy}), DW'(0));
        chk("midrst_cmd_addr", DW'({app_cmd, app_addr}), DW'(0));
        chki("midrst_beats", fire_cnt - f0, 2);
        exp_q.delete();
        done_q.delete();
        wr_pushed = wr_fired;
        @(posedge aclk); #1;
        aresetn = 1'b1;
        repeat (2) begin
            @(posedge aclk); #1;
            chk("post_rst_no_done", DW'({wr_done, busy}), DW'(0));
        end
        f0 = fire_cnt;
        push_burst(0, 28'h3000, 2);
        set_req(0, 28'h3000, 5'd2);
        wait_done(0, d);
        chki("post_rst_beats", fire_cnt - f0, 2);

        repeat (3) @(posedge aclk);
        #1;
        chki("sb_cmds_left", exp_q.size(), 0);
        chki("sb_dones_left", done_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
